// File: rtl/dac_interleave_tx.sv
// dac_interleave_tx
//   Transmit side of the dual-channel converter path. Packed signed A/B sample pairs are queued
//   in a small FIFO. Each pair is converted from two's complement to offset binary and driven
//   onto one 14-bit DAC bus, time-interleaved as the A word followed by the B word.
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   en             level: 1 = start/keep transmitting, 0 = stop after the current pair
//   s_data         packed pair: [27:14] = A signed, [13:0] = B signed
//   s_valid        s_data valid
//   s_ready        FIFO can accept (not full); a transfer happens when s_valid && s_ready
//   dac_data       registered offset-binary DAC word
//   dac_sel        1 = dac_data holds an A word, 0 = B word or idle
//   running        1 while in RUN
//   underflow_cnt  pairs missed in RUN because the FIFO was empty; saturates
module dac_interleave_tx #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PRIME_LEVEL    = 2,
  parameter bit          UNDERFLOW_HOLD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [27:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [13:0] dac_data,
  output logic        dac_sel,
  output logic        running,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [13:0] MID = 14'h2000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [27:0]   mem [FIFO_DEPTH];
  logic [13:0]   dac_data_q, dac_data_d;
  logic          dac_sel_q, dac_sel_d;
  logic [13:0]   hold_a_q, hold_a_d;
  logic [13:0]   hold_b_q, hold_b_d;
  logic [15:0]   underflow_q, underflow_d;
  logic          push, pop, flush;
  logic [27:0]   head;

  function automatic logic [13:0] to_offset(input logic [13:0] x);
    return {~x[13], x[12:0]};
  endfunction

  assign s_ready       = (count_q != CW'(FIFO_DEPTH));
  assign push          = s_valid && s_ready;
  assign head          = mem[rd_ptr_q];
  assign dac_data      = dac_data_q;
  assign dac_sel       = dac_sel_q;
  assign running       = (state_q == ST_RUN);
  assign underflow_cnt = underflow_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dac_data_d  = MID;
    dac_sel_d   = 1'b0;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    underflow_d = underflow_q;
    pop         = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        phase_d = 1'b0;
        if (!en) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (count_q >= CW'(PRIME_LEVEL)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!phase_q) begin
          // Stopping in phase 0 starts no new pair, so a pair is never split.
          if (!en) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
          end else begin
            phase_d   = 1'b1;
            dac_sel_d = 1'b1;
            if (count_q != '0) begin
              pop        = 1'b1;
              dac_data_d = to_offset(head[27:14]);
              hold_a_d   = to_offset(head[27:14]);
              hold_b_d   = to_offset(head[13:0]);
            end else begin
              if (underflow_q != 16'hFFFF) underflow_d = underflow_q + 16'd1;
              if (UNDERFLOW_HOLD) begin
                dac_data_d = hold_a_q;
              end else begin
                dac_data_d = MID;
                hold_b_d   = MID;
              end
            end
          end
        end else begin
          // B word always completes, even when en has dropped.
          phase_d    = 1'b0;
          dac_data_d = hold_b_q;
          if (!en) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dac_data_q  <= MID;
      dac_sel_q   <= 1'b0;
      hold_a_q    <= MID;
      hold_b_q    <= MID;
      underflow_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      dac_data_q  <= dac_data_d;
      dac_sel_q   <= dac_sel_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      underflow_q <= underflow_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_dac_interleave_tx.sv
module tb_dac_interleave_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic [27:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [13:0] dac_data;
  logic        dac_sel;
  logic        running;
  logic [15:0] underflow_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dac_interleave_tx dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dac_data     (dac_data),
    .dac_sel      (dac_sel),
    .running      (running),
    .underflow_cnt(underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] pack(input int a, input int b);
    logic [31:0] av;
    logic [31:0] bv;
    av = a;
    bv = b;
    return {av[13:0], bv[13:0]};
  endfunction

  task automatic push_pair(input int a, input int b);
    s_data  = pack(a, b);
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [13:0] data, input logic sel);
    check_eq({tag, "_data"}, {18'd0, dac_data}, {18'd0, data});
    check_eq({tag, "_sel"}, {31'd0, dac_sel}, {31'd0, sel});
  endtask

  // Backpressure vectors: A/B signed inputs and their offset-binary words
  int          bp_a   [6] = '{1, -2, 4000, 8191, 7, 7};
  int          bp_b   [6] = '{2, 100, -4000, -8192, 7, 7};
  logic [13:0] bp_word[8] = '{14'h2001, 14'h2002, 14'h1FFE, 14'h2064,
                              14'h2FA0, 14'h1060, 14'h3FFF, 14'h0000};

  initial begin
    bit found;
    rst     = 1'b1;
    en      = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    step();
    step();
    check_word("reset", 14'h2000, 1'b0);
    check_eq("reset_running", {31'd0, running}, 32'd0);
    check_eq("reset_ready", {31'd0, s_ready}, 32'd1);
    check_eq("reset_ucnt", {16'd0, underflow_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // Conversion extremes
    push_pair(-8192, 8191);
    push_pair(0, -1);
    en = 1'b1;
    step();                       // IDLE -> PRIME
    step();                       // PRIME -> RUN
    check_eq("conv_running", {31'd0, running}, 32'd1);
    check_word("conv_midscale_before_a", 14'h2000, 1'b0);
    step(); check_word("conv_a0", 14'h0000, 1'b1);
    step(); check_word("conv_b0", 14'h3FFF, 1'b0);
    step(); check_word("conv_a1", 14'h2000, 1'b1);
    step(); check_word("conv_b1", 14'h1FFF, 1'b0);

    // Underflow: FIFO now empty
    for (int i = 0; i < 10; i++) begin
      step();
      check_word("uf_a", 14'h2000, 1'b1);
      check_eq("uf_cnt", {16'd0, underflow_cnt}, i + 1);
      step();
      check_word("uf_b", 14'h2000, 1'b0);
    end
    // Jump the counter near its ceiling instead of simulating 65k misses
    force dut.underflow_q = 16'hFFFD;
    step();
    release dut.underflow_q;
    for (int i = 0; i < 8; i++) step();
    check_eq("uf_saturate", {16'd0, underflow_cnt}, 32'h0000FFFF);

    // Stop in phase 1: B completes, then IDLE, remaining FIFO entry flushed
    push_pair(10, 20);
    push_pair(30, 40);
    push_pair(50, 60);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (dac_sel && dac_data == 14'h201E) found = 1'b1;
      else step();
    end
    check_eq("stop1_found_a", {31'd0, found}, 32'd1);
    en = 1'b0;
    step();
    check_word("stop1_b", 14'h2028, 1'b0);
    check_eq("stop1_running", {31'd0, running}, 32'd0);
    step();
    check_word("stop1_idle", 14'h2000, 1'b0);
    check_eq("stop1_ready", {31'd0, s_ready}, 32'd1);

    // Priming: one pair is not enough, second pair starts RUN
    en = 1'b1;
    push_pair(1234, -2000);       // IDLE -> PRIME, count 1
    step();
    step();
    check_eq("prime_one_running", {31'd0, running}, 32'd0);
    check_word("prime_one_mid", 14'h2000, 1'b0);
    push_pair(-1, 5);             // count reaches 2
    check_eq("prime_two_running0", {31'd0, running}, 32'd0);
    step();
    check_eq("prime_two_running1", {31'd0, running}, 32'd1);
    check_word("prime_mid", 14'h2000, 1'b0);
    step(); check_word("prime_a0", 14'h24D2, 1'b1);
    step(); check_word("prime_b0", 14'h1830, 1'b0);
    step(); check_word("prime_a1", 14'h1FFF, 1'b1);
    step(); check_word("prime_b1", 14'h2005, 1'b0);

    // Stop in phase 0: no new A word
    en = 1'b0;
    step();
    check_word("stop0_idle", 14'h2000, 1'b0);
    check_eq("stop0_running", {31'd0, running}, 32'd0);

    // Backpressure: six pairs offered while idle, four accepted
    for (int i = 0; i < 6; i++) begin
      s_data  = pack(bp_a[i], bp_b[i]);
      s_valid = 1'b1;
      check_eq("bp_ready", {31'd0, s_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    s_valid = 1'b0;
    check_eq("bp_full", {31'd0, s_ready}, 32'd0);
    en = 1'b1;
    step();
    step();
    check_eq("bp_ready_before_pop", {31'd0, s_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_word("bp_word", bp_word[i], ((i % 2) == 0) ? 1'b1 : 1'b0);
      if (i == 0) check_eq("bp_ready_after_pop", {31'd0, s_ready}, 32'd1);
    end
    step();
    check_word("bp_then_underflow", 14'h2000, 1'b1);
    check_eq("bp_ucnt_sat", {16'd0, underflow_cnt}, 32'h0000FFFF);

    // Asynchronous reset mid-RUN
    push_pair(100, 200);
    #2;
    rst = 1'b1;
    #1;
    check_word("areset", 14'h2000, 1'b0);
    check_eq("areset_running", {31'd0, running}, 32'd0);
    check_eq("areset_ready", {31'd0, s_ready}, 32'd1);
    check_eq("areset_ucnt", {16'd0, underflow_cnt}, 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
